// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB constants, types and helpers
// Purpose: core-wide CDB source indices, ROB tag width and arbiter helpers.
// Ports: none (package).
package cdb_arbiter_pkg;

  // Producer indices on the common data bus
  localparam int CDB_NUM_SRC = 2;
  localparam int CDB_SRC_RS  = 0;
  localparam int CDB_SRC_LSB = 1;

  // ROB tag width follows the reorder-buffer id type; tag 0 means "no result"
  localparam int RO_BUFFER_ID_W = 4;
  localparam int CDB_DATA_W     = 32;
  localparam int STAT_W         = 32;

  typedef logic [RO_BUFFER_ID_W-1:0] ro_buffer_id_t;

  // Per-cycle action applied to the CDB output registers
  typedef enum logic [1:0] {
    CDB_HOLD  = 2'd0,  // rdy low: freeze everything
    CDB_IDLE  = 2'd1,  // no candidate: bus goes idle, value kept
    CDB_GRANT = 2'd2,  // broadcast the granted entry
    CDB_FLUSH = 2'd3   // misprediction: bus idle, rr pointer rewound
  } cdb_op_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer/CDB bundle between the core and the CDB arbiter
// Purpose: groups control, producer push, backpressure, CDB and stats signals.
// Ports (signals): rdy, flush, src_dest_i, src_value_i (to arbiter);
//   src_full_o, cdb_dest_o, cdb_value_o, stat_grant_o, stat_stall_o (from arbiter).
// Modports: master = core/producer side, slave = arbiter side.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int NUM_SRC  = CDB_NUM_SRC,
  parameter int ROB_ID_W = RO_BUFFER_ID_W,
  parameter int DATA_W   = CDB_DATA_W
) ();

  logic                         rdy;
  logic                         flush;
  logic [NUM_SRC*ROB_ID_W-1:0]  src_dest_i;
  logic [NUM_SRC*DATA_W-1:0]    src_value_i;
  logic [NUM_SRC-1:0]           src_full_o;
  logic [ROB_ID_W-1:0]          cdb_dest_o;
  logic [DATA_W-1:0]            cdb_value_o;
  logic [NUM_SRC*STAT_W-1:0]    stat_grant_o;
  logic [NUM_SRC*STAT_W-1:0]    stat_stall_o;

  modport master (
    output rdy, flush, src_dest_i, src_value_i,
    input  src_full_o, cdb_dest_o, cdb_value_o, stat_grant_o, stat_stall_o
  );

  modport slave (
    input  rdy, flush, src_dest_i, src_value_i,
    output src_full_o, cdb_dest_o, cdb_value_o, stat_grant_o, stat_stall_o
  );

endinterface

// File: rtl/cdb_queue.sv
// rtl/cdb_queue.sv - per-producer result FIFO feeding the CDB arbiter
// Purpose: DEPTH x W circular FIFO with simultaneous push/pop and synchronous clear.
// Ports: clk, rst (sync, active-high); en_i freezes all state when low;
//   clr_i discards contents; push_i/data_i enqueue; pop_i dequeues;
//   head_o oldest entry; count_o occupancy; full_o count == DEPTH.
module cdb_queue #(
  parameter  int DEPTH = 2,
  parameter  int W     = 36,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A pop in the same cycle frees a slot, so a push into a full queue is
  // accepted only when paired with a pop; otherwise it is dropped.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_pop)  rd_d = ptr_inc(rd_q);
    if (do_push) wr_d = ptr_inc(wr_q);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && en_i && !clr_i && do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
// Purpose: one queue per producer (RS ALU, LSB); each cycle the first candidate
//   from rr_ptr upward is broadcast on the CDB the next cycle. Empty queues
//   let a same-cycle push bypass straight to arbitration.
// Ports: clk, rst (sync, active-high); bus (cdb_arbiter_if.slave):
//   rdy freeze, flush discard, src_dest_i/src_value_i pushes, src_full_o
//   backpressure, cdb_dest_o/cdb_value_o broadcast, stat_grant_o/stat_stall_o.
// Config: CDB_ARB_STATS_EN enables saturating per-source grant/stall counters;
//   when undefined the stat outputs are tied to zero.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int NUM_SRC  = CDB_NUM_SRC,
  parameter int DEPTH    = 2,
  parameter int ROB_ID_W = RO_BUFFER_ID_W,
  parameter int DATA_W   = CDB_DATA_W
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ROB_ID_W + DATA_W;
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [ROB_ID_W-1:0] dest_in  [NUM_SRC];
  logic [DATA_W-1:0]   value_in [NUM_SRC];
  logic [ENT_W-1:0]    head     [NUM_SRC];
  logic [ENT_W-1:0]    cand_ent [NUM_SRC];
  logic [CNT_W-1:0]    count    [NUM_SRC];
  logic [NUM_SRC-1:0]  head_v;
  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  push_en;
  logic [NUM_SRC-1:0]  pop_en;
  logic [NUM_SRC-1:0]  full;

  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_v;
  logic [ENT_W-1:0]    gnt_ent;
  cdb_op_e             cdb_op;

  logic [ROB_ID_W-1:0] dest_q;
  logic [DATA_W-1:0]   value_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign dest_in[i]  = bus.src_dest_i[i*ROB_ID_W +: ROB_ID_W];
    assign value_in[i] = bus.src_value_i[i*DATA_W +: DATA_W];
    assign head_v[i]   = (count[i] != '0);
    assign cand[i]     = head_v[i] || (dest_in[i] != '0);
    // Queued entries always go first; the bypass only exists on an empty queue.
    assign cand_ent[i] = head_v[i] ? head[i] : {dest_in[i], value_in[i]};
    assign pop_en[i]   = gnt_v && (gnt_idx == IDX_W'(i)) && head_v[i];
    // A granted bypass is consumed on the bus and never enqueued.
    assign push_en[i]  = (dest_in[i] != '0) &&
                         !(gnt_v && (gnt_idx == IDX_W'(i)) && !head_v[i]);

    cdb_queue #(.DEPTH(DEPTH), .W(ENT_W)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .en_i    (bus.rdy),
      .clr_i   (bus.flush),
      .push_i  (push_en[i]),
      .pop_i   (pop_en[i]),
      .data_i  ({dest_in[i], value_in[i]}),
      .head_o  (head[i]),
      .count_o (count[i]),
      .full_o  (full[i])
    );
  end

  assign bus.src_full_o  = full;
  assign bus.cdb_dest_o  = dest_q;
  assign bus.cdb_value_o = value_q;

  // Round-robin scan starting at rr_q, wrapping modulo NUM_SRC.
  always_comb begin
    logic [IDX_W-1:0] sel;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    sel     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel = IDX_W'((int'(rr_q) + k) % NUM_SRC);
      if (!gnt_v && cand[sel]) begin
        gnt_v   = 1'b1;
        gnt_idx = sel;
      end
    end
    gnt_ent = cand_ent[gnt_idx];
    rr_d    = gnt_v ? IDX_W'(rr_next(int'(gnt_idx), NUM_SRC)) : rr_q;
  end

  // Flush outranks a grant; rdy low outranks both.
  always_comb begin
    cdb_op = CDB_HOLD;
    if (!bus.rdy)      cdb_op = CDB_HOLD;
    else if (bus.flush) cdb_op = CDB_FLUSH;
    else if (gnt_v)    cdb_op = CDB_GRANT;
    else               cdb_op = CDB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q  <= '0;
      value_q <= '0;
      rr_q    <= '0;
    end else begin
      case (cdb_op)
        CDB_GRANT: begin
          dest_q  <= gnt_ent[ENT_W-1 -: ROB_ID_W];
          value_q <= gnt_ent[DATA_W-1:0];
          rr_q    <= rr_d;
        end
        CDB_IDLE: begin
          dest_q <= '0;
        end
        CDB_FLUSH: begin
          dest_q <= '0;
          rr_q   <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [NUM_SRC];
  logic [STAT_W-1:0] stall_cnt_q [NUM_SRC];

  // Stats survive flush; only rst clears them. Arbitration happens only on a
  // CDB_GRANT cycle (IDLE implies no candidates at all).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        grant_cnt_q[i] <= '0;
        stall_cnt_q[i] <= '0;
      end
    end else if (cdb_op == CDB_GRANT) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (gnt_idx == IDX_W'(i)) begin
          grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
        end else if (cand[i]) begin
          stall_cnt_q[i] <= sat_inc(stall_cnt_q[i]);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
    assign bus.stat_grant_o[i*STAT_W +: STAT_W] = grant_cnt_q[i];
    assign bus.stat_stall_o[i*STAT_W +: STAT_W] = stall_cnt_q[i];
  end
`else
  assign bus.stat_grant_o = '0;
  assign bus.stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  ed;
    logic [31:0] ev;
    logic [1:0]  ef;
  } vec_t;

  typedef struct {
    logic [3:0]  ed;
    logic [31:0] ev;
    logic [1:0]  ef;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   illegal_cnt = 0;
  vec_t vecs[$];
  exp_t sb[$];

  cdb_arbiter_if #(.NUM_SRC(2), .ROB_ID_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.NUM_SRC(2), .DEPTH(2), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] v0(input logic [3:0] t);
    return 32'hA000_0000 | {28'h0, t};
  endfunction

  function automatic logic [31:0] v1(input logic [3:0] t);
    return 32'hB000_0000 | {28'h0, t};
  endfunction

  // Producer-protocol monitor: a push while the source's full flag is high.
  always @(posedge clk) begin
    if (!rst && bus.rdy && !bus.flush) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.src_dest_i[i*4 +: 4] != 4'd0 && bus.src_full_o[i]) illegal_cnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] ed,
                     input logic [31:0] ev, input logic [1:0] ef);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.ed = ed; v.ev = ev; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic fl, input logic rd,
                      input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] ed, input logic [31:0] ev, input logic [1:0] ef,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.flush       = fl;
    bus.rdy         = rd;
    bus.src_dest_i  = {d1, d0};
    bus.src_value_i = {v1(d1), v0(d0)};
    e.ed = ed; e.ev = ev; e.ef = ef;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_dest"}, 64'(bus.cdb_dest_o), 64'(e.ed));
      chk({nm, "_value"}, 64'(bus.cdb_value_o), 64'(e.ev));
      chk({nm, "_full"}, 64'(bus.src_full_o), 64'(e.ef));
    end
  endtask

  task automatic chk_stats(input string nm, input logic [31:0] g0, input logic [31:0] g1,
                           input logic [31:0] s0, input logic [31:0] s1);
    chk({nm, "_grant0"}, 64'(bus.stat_grant_o[CDB_SRC_RS*32 +: 32]), 64'(g0));
    chk({nm, "_grant1"}, 64'(bus.stat_grant_o[CDB_SRC_LSB*32 +: 32]), 64'(g1));
    chk({nm, "_stall0"}, 64'(bus.stat_stall_o[CDB_SRC_RS*32 +: 32]), 64'(s0));
    chk({nm, "_stall1"}, 64'(bus.stat_stall_o[CDB_SRC_LSB*32 +: 32]), 64'(s1));
  endtask

  initial begin
    bus.rdy         = 1'b1;
    bus.flush       = 1'b0;
    bus.src_dest_i  = '0;
    bus.src_value_i = '0;

    // Contention from rr=0 with producers honouring src_full_o, then two
    // forced src1 pushes while full (the second is dropped, tag 3 never shows).
    add(4'd1, 4'd9,  4'd1,  v0(4'd1),  2'b00);
    add(4'd2, 4'd10, 4'd9,  v1(4'd9),  2'b00);
    add(4'd3, 4'd11, 4'd2,  v0(4'd2),  2'b10);
    add(4'd4, 4'd0,  4'd10, v1(4'd10), 2'b01);
    add(4'd0, 4'd12, 4'd3,  v0(4'd3),  2'b10);
    add(4'd5, 4'd0,  4'd11, v1(4'd11), 2'b01);
    add(4'd0, 4'd13, 4'd4,  v0(4'd4),  2'b10);
    add(4'd6, 4'd0,  4'd12, v1(4'd12), 2'b01);
    add(4'd0, 4'd14, 4'd5,  v0(4'd5),  2'b10);
    add(4'd7, 4'd0,  4'd13, v1(4'd13), 2'b01);
    add(4'd0, 4'd15, 4'd6,  v0(4'd6),  2'b10);
    add(4'd0, 4'd2,  4'd14, v1(4'd14), 2'b10);
    add(4'd0, 4'd3,  4'd7,  v0(4'd7),  2'b10);
    add(4'd0, 4'd0,  4'd15, v1(4'd15), 2'b00);
    add(4'd0, 4'd0,  4'd2,  v1(4'd2),  2'b00);
    add(4'd0, 4'd0,  4'd0,  v1(4'd2),  2'b00);

    // Reset state
    step(1, 0, 1, 4'd0, 4'd0, 4'd0, 32'd0, 2'b00, "rst0");
    step(1, 0, 1, 4'd0, 4'd0, 4'd0, 32'd0, 2'b00, "rst1");
    chk_stats("rst_stats", 0, 0, 0, 0);

    // Single source: bypass visible next cycle, then idle with value held
    step(0, 0, 1, 4'd3, 4'd0, 4'd3, v0(4'd3), 2'b00, "single");
    step(0, 0, 1, 4'd0, 4'd0, 4'd0, v0(4'd3), 2'b00, "single_idle");

    // Reset rewinds rr and clears stats; pushes during rst are ignored
    step(1, 0, 1, 4'd1, 4'd9, 4'd0, 32'd0, 2'b00, "rst2");

    for (int i = 0; i < vecs.size(); i++) begin
      step(0, 0, 1, vecs[i].d0, vecs[i].d1, vecs[i].ed, vecs[i].ev, vecs[i].ef,
           $sformatf("vec%0d", i));
      if (i == 7) begin
`ifdef CDB_ARB_STATS_EN
        chk_stats("stats8", 4, 4, 4, 4);
`else
        chk_stats("stats8", 0, 0, 0, 0);
`endif
      end
    end
    chk("illegal_push", 64'(illegal_cnt), 64'd2);

    // Flush with a full src0 queue and new pushes in the flush cycle
    step(0, 0, 1, 4'd1, 4'd9,  4'd1,  v0(4'd1),  2'b00, "fl_a");
    step(0, 0, 1, 4'd2, 4'd10, 4'd9,  v1(4'd9),  2'b00, "fl_b");
    step(0, 0, 1, 4'd3, 4'd11, 4'd2,  v0(4'd2),  2'b10, "fl_c");
    step(0, 0, 1, 4'd4, 4'd0,  4'd10, v1(4'd10), 2'b01, "fl_d");
    step(0, 1, 1, 4'd5, 4'd12, 4'd0,  v1(4'd10), 2'b00, "flush");
    step(0, 0, 1, 4'd0, 4'd0,  4'd0,  v1(4'd10), 2'b00, "fl_idle0");
    step(0, 0, 1, 4'd0, 4'd0,  4'd0,  v1(4'd10), 2'b00, "fl_idle1");
    step(0, 0, 1, 4'd6, 4'd13, 4'd6,  v0(4'd6),  2'b00, "fl_rr0");
    step(0, 0, 1, 4'd0, 4'd0,  4'd13, v1(4'd13), 2'b00, "fl_after");

    // rdy stall: tag 5 queued on src1, frozen 3 cycles, inputs ignored
    step(0, 0, 1, 4'd7, 4'd5, 4'd7, v0(4'd7), 2'b00, "rdy_load");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 4'd8, 4'd9, 4'd7, v0(4'd7), 2'b00, $sformatf("rdy_hold%0d", i));
    end
    step(0, 0, 1, 4'd0, 4'd0, 4'd5, v1(4'd5), 2'b00, "rdy_resume");
    step(0, 0, 1, 4'd0, 4'd0, 4'd0, v1(4'd5), 2'b00, "rdy_idle");

    // Reset mid-operation: queued tag 9 is lost
    step(0, 0, 1, 4'd1, 4'd9,  4'd1, v0(4'd1), 2'b00, "mid_a");
    step(1, 0, 1, 4'd2, 4'd10, 4'd0, 32'd0,    2'b00, "mid_rst");
    chk_stats("mid_stats", 0, 0, 0, 0);
    step(0, 0, 1, 4'd0, 4'd0,  4'd0, 32'd0,    2'b00, "mid_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
